// File: rtl/sreg_pkg.sv
// ============================================================================
// Module   : sreg_pkg
// Brief    : Shared state encoding and default geometry for the sreg links.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sreg_pkg;

    localparam int C_DWIDTH = 8;
    localparam int C_CLKDIV = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sreg_tx_if.sv
// ============================================================================
// Module   : sreg_tx_if
// Brief    : Load handshake and serial-link bundle of the sreg transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sreg_tx_if #(
    parameter int DWIDTH = sreg_pkg::C_DWIDTH
);

    logic [DWIDTH-1:0] data_in;
    logic              load_n;
    logic              busy;
    logic              done;
    logic              sclk;
    logic              sdo;
    logic [7:0]        debug;

    modport master (
        output data_in,
        output load_n,
        input  busy,
        input  done,
        input  sclk,
        input  sdo,
        input  debug
    );

    modport slave (
        input  data_in,
        input  load_n,
        output busy,
        output done,
        output sclk,
        output sdo,
        output debug
    );

endinterface

`default_nettype wire

// File: rtl/sreg_tx_tick.sv
// ============================================================================
// Module   : sreg_tx_tick
// Brief    : Bit-period divider; produces the sclk level and a bit_end strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sreg_tx_tick #(
    parameter int CLKDIV = sreg_pkg::C_CLKDIV
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear,
    input  wire logic run,
    output logic      sclk_level,
    output logic      bit_end
);

    localparam int                C_DIVW     = $clog2(2 * CLKDIV);
    localparam logic [C_DIVW-1:0] C_DIV_LAST = C_DIVW'(2 * CLKDIV - 1);
    localparam logic [C_DIVW-1:0] C_DIV_HALF = C_DIVW'(CLKDIV);
    localparam logic [C_DIVW-1:0] C_DIV_ONE  = C_DIVW'(1);

    logic [C_DIVW-1:0] r_divcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divcnt <= '0;
        end else if (clear || !run) begin
            r_divcnt <= '0;
        end else if (r_divcnt == C_DIV_LAST) begin
            r_divcnt <= '0;
        end else begin
            r_divcnt <= r_divcnt + C_DIV_ONE;
        end
    end

    assign sclk_level = run && (r_divcnt >= C_DIV_HALF);
    assign bit_end    = run && (r_divcnt == C_DIV_LAST);

endmodule

`default_nettype wire

// File: rtl/sreg_tx.sv
// ============================================================================
// Module   : sreg_tx
// Brief    : Parallel-in, MSB-first serial transmitter with generated sclk.
//            Optional trailing even-parity bit when SREG_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sreg_tx
    import sreg_pkg::*;
#(
    parameter int DWIDTH = C_DWIDTH,
    parameter int CLKDIV = C_CLKDIV
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sreg_tx_if.slave  bus
);

`ifdef SREG_TX_PARITY_EN
    localparam int NBITS = DWIDTH + 1;
`else
    localparam int NBITS = DWIDTH;
`endif

    localparam int                C_CNTW     = $clog2(NBITS + 1);
    localparam logic [C_CNTW-1:0] C_BIT_LAST = C_CNTW'(NBITS - 1);
    localparam logic [C_CNTW-1:0] C_CNT_ONE  = C_CNTW'(1);

    state_t            r_state;
    logic [DWIDTH-1:0] r_shreg;
    logic [C_CNTW-1:0] r_bitcnt;
    logic              r_busy;
    logic              r_done;

    logic              w_load;
    logic              w_run;
    logic              w_sclk_level;
    logic              w_bit_end;
    logic [DWIDTH-1:0] w_shift_next;

    assign w_load = (r_state == ST_IDLE) && !bus.load_n;
    assign w_run  = (r_state == ST_SHIFT);

    sreg_tx_tick #(
        .CLKDIV     (CLKDIV)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_load),
        .run        (w_run),
        .sclk_level (w_sclk_level),
        .bit_end    (w_bit_end)
    );

`ifdef SREG_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^bus.data_in;
        end
    end

    // The last data shift lands the parity bit in the MSB for the final period.
    assign w_shift_next = (r_bitcnt == C_CNT_ONE)
                        ? {r_parity, r_shreg[DWIDTH-3:0], 1'b0}
                        : {r_shreg[DWIDTH-2:0], 1'b0};
`else
    assign w_shift_next = {r_shreg[DWIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!bus.load_n) begin
                        r_shreg  <= bus.data_in;
                        r_bitcnt <= C_BIT_LAST;
                        r_state  <= ST_SHIFT;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_bit_end) begin
                        if (r_bitcnt == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_shreg  <= w_shift_next;
                            r_bitcnt <= r_bitcnt - C_CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sclk  = w_sclk_level;
    assign bus.sdo   = w_run & r_shreg[DWIDTH-1];
    assign bus.debug = r_shreg[7:0];

endmodule

`default_nettype wire

// File: tb/tb_sreg_tx.sv
// ============================================================================
// Module   : tb_sreg_tx
// Brief    : Directed self-checking bench for sreg_tx (CLKDIV=2 and CLKDIV=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sreg_tx;

`ifdef SREG_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk;
    logic rst_n;
    int   sel;
    int   n_checks;
    int   n_fail;

    sreg_tx_if #(.DWIDTH(8)) if0 ();
    sreg_tx_if #(.DWIDTH(8)) if1 ();

    sreg_tx #(.DWIDTH(8), .CLKDIV(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    sreg_tx #(.DWIDTH(8), .CLKDIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    wire       s_busy  = (sel == 1) ? if1.busy  : if0.busy;
    wire       s_done  = (sel == 1) ? if1.done  : if0.done;
    wire       s_sclk  = (sel == 1) ? if1.sclk  : if0.sclk;
    wire       s_sdo   = (sel == 1) ? if1.sdo   : if0.sdo;
    wire [7:0] s_debug = (sel == 1) ? if1.debug : if0.debug;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_word(input logic [7:0] d);
        if (NB == 9) return {7'b0, d, ^d};
        return {8'b0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer on DUT s; samples are taken 1 time unit after each edge,
    // sample k being the cycle that follows edge N+k-1 (N = load edge).
    task automatic xfer(input int s, input logic [7:0] d, input bit pulse, input string tag);
        int cd, total, busy_n, done_n, done_at, rises, toggles, phase_bad;
        logic prev_sclk, exp_sclk;
        logic [15:0] got;
        logic [7:0] dbg_first;
        cd = (s == 1) ? 1 : 2;
        total = NB * 2 * cd;
        busy_n = 0; done_n = 0; done_at = 0; rises = 0; toggles = 0; phase_bad = 0;
        prev_sclk = 1'b0; got = '0; dbg_first = '0;
        sel = s;
        tick();
        if (s == 1) begin if1.data_in = d; if1.load_n = 1'b0; end
        else begin        if0.data_in = d; if0.load_n = 1'b0; end
        tick();
        if0.load_n = 1'b1;
        if1.load_n = 1'b1;
        for (int k = 1; k <= total + 4; k++) begin
            if (k == 1) dbg_first = s_debug;
            if (s_busy) busy_n++;
            if (s_done) begin done_n++; done_at = k; end
            exp_sclk = (k <= total) ? (((k - 1) % (2 * cd)) >= cd) : 1'b0;
            if (s_sclk !== exp_sclk) phase_bad++;
            if (s_sclk !== prev_sclk) toggles++;
            if (s_sclk && !prev_sclk) begin
                rises++;
                got = {got[14:0], s_sdo};
            end
            prev_sclk = s_sclk;
            if (pulse && s == 0) if0.load_n = ((k % 3) == 0 && k < total - 2) ? 1'b0 : 1'b1;
            tick();
        end
        if0.load_n = 1'b1;
        check_eq($sformatf("%s_dbg_load", tag), 32'(dbg_first), 32'(d));
        check_eq($sformatf("%s_rises", tag), rises, NB);
        check_eq($sformatf("%s_bits", tag), 32'(got), 32'(exp_word(d)));
        check_eq($sformatf("%s_toggles", tag), toggles, 2 * NB);
        check_eq($sformatf("%s_sclk_phase", tag), phase_bad, 0);
        check_eq($sformatf("%s_busy_len", tag), busy_n, total + 1);
        check_eq($sformatf("%s_done_at", tag), done_at, total + 1);
        check_eq($sformatf("%s_done_cnt", tag), done_n, 1);
        check_eq($sformatf("%s_dbg_end", tag), 32'(s_debug),
                 (NB == 9) ? 32'({^d, 7'b0}) : 32'({d[0], 7'b0}));
    endtask

    initial begin
        int n, gap, bad, rises;
        logic prev;
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        rst_n    = 1'b0;
        if0.data_in = '0; if0.load_n = 1'b1;
        if1.data_in = '0; if1.load_n = 1'b1;
        repeat (3) tick();
        check_eq("reset_outs0", {if0.busy, if0.done, if0.sclk, if0.sdo, if0.debug}, 0);
        check_eq("reset_outs1", {if1.busy, if1.done, if1.sclk, if1.sdo, if1.debug}, 0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if0.busy || if0.done || if0.sclk || if0.sdo) bad++;
        end
        check_eq("idle_quiet", bad, 0);

        xfer(0, 8'hA5, 1'b0, "a5");
        xfer(0, 8'h3C, 1'b1, "3c_pulsed");

        // load_n held low: back-to-back transfers separated by one IDLE cycle
        sel = 0;
        if0.data_in = 8'h3C;
        if0.load_n  = 1'b0;
        n = 0;
        while (!if0.busy && n < 10) begin tick(); n++; end
        check_eq("hold_start", if0.busy, 1);
        n = 0;
        while (if0.busy && n < 100) begin tick(); n++; end
        check_eq("hold_len", n, NB * 4 + 1);
        gap = 0;
        while (!if0.busy && gap < 10) begin tick(); gap++; end
        check_eq("hold_gap", gap, 1);
        if0.load_n = 1'b1;
        n = 0;
        while (if0.busy && n < 100) begin tick(); n++; end
        check_eq("hold_end", if0.busy, 0);

        // Asynchronous reset after the 4th sclk rise of an all-ones word
        tick();
        if0.data_in = 8'hFF;
        if0.load_n  = 1'b0;
        tick();
        if0.load_n = 1'b1;
        rises = 0; prev = 1'b0; n = 0;
        while (rises < 4 && n < 100) begin
            if (if0.sclk && !prev) rises++;
            prev = if0.sclk;
            if (rises < 4) begin tick(); n++; end
        end
        check_eq("rst_mid_rises", rises, 4);
        check_eq("rst_mid_pre", {if0.busy, if0.sclk, if0.sdo}, 3'b111);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_outs", {if0.busy, if0.sclk, if0.sdo, if0.done}, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if0.busy || if0.done || if0.sclk) bad++;
        end
        check_eq("rst_mid_quiet", bad, 0);

        xfer(0, 8'h07, 1'b0, "x07");
        xfer(1, 8'h80, 1'b0, "cd1_80");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
